stage_fetch: RTL and testbench
==============================

# stage_fetch

Instruction fetch stage: the producing end of the fetch-to-decode interface (`inst`, `pc`, `flush`) consumed by the decode stage. It keeps the program counter, issues in-order requests to instruction memory, buffers returned words in a small FIFO, and presents one instruction per cycle, or a flush bubble, to decode. It honours the decode `stall` and handles taken-branch/jump redirects from execute by discarding wrong-path work.

## Interface
- `FIFO_DEPTH`, default 4: instruction buffer entries; power of two, ≥2; also the cap on outstanding plus buffered fetches.
- `RESET_PC`, default 0: first fetch address after reset.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: core enable; low freezes PC, FIFO pop and outputs.
- `stall` input 1: decode cannot accept; outputs hold.
- `redirect` input 1: taken branch/jump, one-cycle pulse.
- `redirect_pc` input `INST_ADDR_W`: new fetch address, valid with `redirect`.
- `imem_req` output 1: fetch request valid.
- `imem_addr` output `INST_ADDR_W`: fetch address (current PC).
- `imem_ready` input 1: request accepted when `imem_req && imem_ready`.
- `imem_rvalid` input 1: response valid; in order, ≥1 cycle after acceptance, never back-pressured.
- `imem_rdata` input `INST_W`: returned instruction.
- `out_inst` output `INST_W`: instruction to decode.
- `out_pc` output `INST_ADDR_W`: address of `out_inst`.
- `out_flush` output 1: 1 = bubble; decode treats `out_inst` as invalid.

## Operation
- PC register; each accepted request does PC += 4 (wraps at `INST_ADDR_W`).
- Credit: `imem_req = en && !redirect && (fifo_count + outstanding < FIFO_DEPTH)`. Pops in the same cycle are not credited. The FIFO never overflows.
- `outstanding` increments on accept and decrements on a counted `imem_rvalid`. Both in the same cycle leave it unchanged.
- Each FIFO entry stores {inst, pc}. The entry PC comes from a companion pc-FIFO written at request acceptance, or from a PC counter at response time. Either is acceptable; values must match.
- Output update when `en && !stall`: FIFO non-empty → pop head into `out_inst`/`out_pc`, `out_flush` ← 0; FIFO empty → `out_flush` ← 1, `out_inst`/`out_pc` hold.
- Redirect, acted on only when `en`:
  - PC ← `redirect_pc`.
  - FIFO cleared.
  - `out_flush` ← 1, overriding `stall`.
  - No request issued that cycle.
  - `drop_cnt` ← outstanding after that cycle's return, if any. A return in the redirect cycle is itself discarded.
- While `drop_cnt > 0`, each `imem_rvalid` decrements `drop_cnt` and is discarded. Discarded responses do not enter the FIFO.
- `imem_rvalid` is always captured, even with `en` low. Credit guarantees space.
- A redirect while `drop_cnt > 0` adds the new outstanding count. In-flight stale responses are never delivered.

## Timing
- Reset values: `out_flush`=1, `out_inst`=32'h0000_0013 (NOP), `out_pc`=`RESET_PC`, PC=`RESET_PC`, FIFO empty, `outstanding`=0, `drop_cnt`=0. `imem_req`=0 while `rst_n` low.
- First request: the first cycle after `rst_n` rises, if `en`=1.
- Latency without bypass: response in cycle R → FIFO write at edge R → earliest output at edge R+1.
- Throughput: one instruction per cycle when `imem_ready`=1 and single-cycle memory latency.
- Redirect in cycle T: `imem_addr`=`redirect_pc` with `imem_req` high from cycle T+1. `out_flush`=1 from edge T.
- Stall and empty FIFO together: outputs hold; `out_flush` does not change.
- Reset mid-operation clears all state immediately. Responses to pre-reset requests are not expected; the memory is reset together with this block.

## Configuration
- `FE_BYPASS_EN` defined: when the FIFO is empty, `en && !stall`, `drop_cnt`=0 and `imem_rvalid`=1, `imem_rdata` goes directly to the output registers at edge R and is not written to the FIFO. Latency drops by one cycle.
- Undefined: all responses pass through the FIFO. Minimum response-to-output latency is two edges.

## Test plan
- Reset with `RESET_PC`=0x100, single-cycle memory, no stall → `imem_addr` 0x100, 0x104, 0x108…; `out_pc` sequence identical, `out_flush`=0 from the first delivered word; first `out_flush` after reset is 1.
- `stall` held high for 6 cycles while streaming → `imem_req` drops after 4 buffered/outstanding; outputs hold; on release, delivery resumes with no missing or duplicated PC.
- 3 requests outstanding, memory latency 3, `redirect` to 0x200 → 3 stale responses discarded; next `out_pc`=0x200 with `out_flush`=0; `out_flush`=1 from the redirect edge.
- `redirect` while `stall`=1 and FIFO full → `out_flush`=1 next cycle, FIFO empty, fetch restarts at `redirect_pc`.
- `imem_ready` toggling 1,0,0,1 → PC advances only on accepted cycles; delivered PCs are contiguous.
- With `FE_BYPASS_EN`, empty FIFO, response at cycle R → `out_inst` valid at edge R; without the macro → edge R+1.

Source files
------------

// File: rtl/stage_fetch.sv
// Instruction fetch stage: PC, in-order imem requests, instruction FIFO and decode-facing outputs.
// Optional FE_BYPASS_EN: a response that finds the FIFO empty goes straight to the output registers.
module stage_fetch #(
  parameter int                     FIFO_DEPTH  = 4,
  parameter int                     INST_ADDR_W = 32,
  parameter int                     INST_W      = 32,
  parameter logic [INST_ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [INST_ADDR_W-1:0] redirect_pc,
  output logic                   imem_req,
  output logic [INST_ADDR_W-1:0] imem_addr,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [INST_W-1:0]      imem_rdata,
  output logic [INST_W-1:0]      out_inst,
  output logic [INST_ADDR_W-1:0] out_pc,
  output logic                   out_flush
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [INST_W-1:0]      NOP_INST = INST_W'(32'h0000_0013);
  localparam logic [INST_ADDR_W-1:0] PC_STEP  = INST_ADDR_W'(4);

  logic [INST_ADDR_W-1:0] r_pc;
  logic [INST_ADDR_W-1:0] r_resp_pc;
  logic [INST_W-1:0]      r_fifo_inst [FIFO_DEPTH];
  logic [INST_ADDR_W-1:0] r_fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       r_outstanding;
  logic [CNT_W-1:0]       r_drop_cnt;
  logic [INST_W-1:0]      r_out_inst;
  logic [INST_ADDR_W-1:0] r_out_pc;
  logic                   r_out_flush;

  logic [CNT_W:0]   w_inflight;
  logic             w_credit;
  logic             w_accept;
  logic             w_redirect;
  logic             w_drop;
  logic             w_resp;
  logic             w_advance;
  logic             w_fifo_empty;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_outstanding_next;

  // Credit counts buffered plus in-flight words, so a response always finds a free slot.
  assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_credit   = w_inflight < (CNT_W + 1)'(FIFO_DEPTH);
  assign imem_req   = rst_n && en && !redirect && w_credit;
  assign imem_addr  = r_pc;
  assign w_accept   = imem_req && imem_ready;

  assign w_redirect   = en && redirect;
  assign w_drop       = imem_rvalid && (w_redirect || (r_drop_cnt != '0));
  assign w_resp       = imem_rvalid && !w_drop;
  assign w_advance    = en && !stall && !w_redirect;
  assign w_fifo_empty = (r_count == '0);

`ifdef FE_BYPASS_EN
  assign w_bypass = w_resp && w_advance && w_fifo_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_resp && !w_bypass;
  assign w_pop  = w_advance && !w_fifo_empty;

  assign w_outstanding_next = r_outstanding + CNT_W'(w_accept) - CNT_W'(imem_rvalid);

  // NOTE: the FIFO storage has no reset; r_count gates every read, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_inst[r_wr_ptr] <= imem_rdata;
      r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_out_inst    <= NOP_INST;
      r_out_pc      <= RESET_PC;
      r_out_flush   <= 1'b1;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (w_redirect) begin
        // Every word still in flight belongs to the wrong path, including any returning now.
        r_pc        <= redirect_pc;
        r_resp_pc   <= redirect_pc;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_drop_cnt  <= w_outstanding_next;
        r_out_flush <= 1'b1;
      end else begin
        if (w_accept) r_pc <= r_pc + PC_STEP;
        if (w_drop)   r_drop_cnt <= r_drop_cnt - CNT_W'(1);
        if (w_resp)   r_resp_pc <= r_resp_pc + PC_STEP;
        if (w_push)   r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        if (w_advance) begin
          if (!w_fifo_empty) begin
            r_out_inst  <= r_fifo_inst[r_rd_ptr];
            r_out_pc    <= r_fifo_pc[r_rd_ptr];
            r_out_flush <= 1'b0;
          end else if (w_bypass) begin
            r_out_inst  <= imem_rdata;
            r_out_pc    <= r_resp_pc;
            r_out_flush <= 1'b0;
          end else begin
            r_out_flush <= 1'b1;
          end
        end
      end
    end
  end

  assign out_inst  = r_out_inst;
  assign out_pc    = r_out_pc;
  assign out_flush = r_out_flush;

endmodule

// File: tb/tb_stage_fetch.sv
// Self-checking bench for stage_fetch: directed scenarios plus randomized traffic against a
// queue-based model of the fetch stage and an in-order instruction memory with variable latency.
module tb_stage_fetch;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h100;
`ifdef FE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_flush;

  always #5 clk = ~clk;

  stage_fetch #(
    .FIFO_DEPTH (DEPTH),
    .INST_ADDR_W(32),
    .INST_W     (32),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .out_inst   (out_inst),
    .out_pc     (out_pc),
    .out_flush  (out_flush)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cnt = 0;

  // Instruction memory: in-order responses, one per cycle at most.
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          mem_last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  // Model: PC, buffered words, in-flight requests tagged stale on redirect, output registers.
  logic [31:0] m_pc;
  logic [31:0] m_fifo_inst[$];
  logic [31:0] m_fifo_pc[$];
  logic [31:0] m_fl_addr[$];
  bit          m_fl_stale[$];
  logic [31:0] m_out_inst;
  logic [31:0] m_out_pc;
  logic        m_out_flush;
  logic [31:0] deliv_pc[$];
  int          deliv_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[17:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC;
    m_fifo_inst.delete();
    m_fifo_pc.delete();
    m_fl_addr.delete();
    m_fl_stale.delete();
    m_out_inst  = 32'h0000_0013;
    m_out_pc    = RST_PC;
    m_out_flush = 1'b1;
  endtask

  task automatic log_delivery(input logic [31:0] pc);
    deliv_pc.push_back(pc);
    deliv_cyc.push_back(cyc);
  endtask

  task automatic clear_log();
    deliv_pc.delete();
    deliv_cyc.delete();
  endtask

  task automatic check_contig(input string name);
    bit ok;
    ok = (deliv_pc.size() > 0);
    for (int i = 1; i < deliv_pc.size(); i++)
      if (deliv_pc[i] != deliv_pc[i-1] + 32'd4) ok = 1'b0;
    check(name, 32'(ok), 32'd1);
  endtask

  // Entered and left just after a falling edge.
  task automatic do_reset(input int cycles);
    rst_n       = 1'b0;
    en          = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    mem_addr_q.delete();
    mem_due_q.delete();
    mem_last_due = 0;
    model_reset();
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_out_flush", 32'(out_flush), 32'd1);
    check("rst_out_inst", out_inst, 32'h0000_0013);
    check("rst_out_pc", out_pc, 32'h100);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare DUT to model, advance memory and model.
  task automatic step(input logic i_en, input logic i_stall, input logic i_redir,
                      input logic [31:0] i_rpc, input logic i_ready);
    bit          req_m;
    bit          deliverable;
    bit          consumed;
    bit          stale;
    logic [31:0] r_addr;
    logic [31:0] r_inst;
    int          lat;
    int          due;
    en          = i_en;
    stall       = i_stall;
    redirect    = i_redir;
    redirect_pc = i_rpc;
    imem_ready  = i_ready;
    if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_addr_q[0]);
      void'(mem_due_q.pop_front());
      void'(mem_addr_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    check("out_flush", 32'(out_flush), 32'(m_out_flush));
    check("out_inst", out_inst, m_out_inst);
    check("out_pc", out_pc, m_out_pc);
    req_m = i_en && !i_redir && (m_fifo_pc.size() + m_fl_addr.size() < DEPTH);
    check("imem_req", 32'(imem_req), 32'(req_m));
    if (req_m) check("imem_addr", imem_addr, m_pc);

    if (imem_req && imem_ready) begin
      acc_cnt++;
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= mem_last_due) due = mem_last_due + 1;
      mem_last_due = due;
      mem_addr_q.push_back(imem_addr);
      mem_due_q.push_back(due);
    end

    deliverable = 1'b0;
    consumed    = 1'b0;
    r_addr      = '0;
    r_inst      = imem_rdata;
    if (imem_rvalid) begin
      if (m_fl_addr.size() == 0) begin
        check("rvalid_without_request", 32'd1, 32'd0);
      end else begin
        r_addr      = m_fl_addr.pop_front();
        stale       = m_fl_stale.pop_front();
        deliverable = !stale && !(i_en && i_redir);
      end
    end
    if (req_m && i_ready) begin
      m_fl_addr.push_back(m_pc);
      m_fl_stale.push_back(1'b0);
      m_pc = m_pc + 32'd4;
    end
    if (i_en && i_redir) begin
      foreach (m_fl_stale[i]) m_fl_stale[i] = 1'b1;
      m_fifo_inst.delete();
      m_fifo_pc.delete();
      m_out_flush = 1'b1;
      m_pc        = i_rpc;
    end else if (i_en && !i_stall) begin
      if (m_fifo_pc.size() > 0) begin
        m_out_inst  = m_fifo_inst.pop_front();
        m_out_pc    = m_fifo_pc.pop_front();
        m_out_flush = 1'b0;
        log_delivery(m_out_pc);
      end else if (BYP && deliverable) begin
        m_out_inst  = r_inst;
        m_out_pc    = r_addr;
        m_out_flush = 1'b0;
        consumed    = 1'b1;
        log_delivery(m_out_pc);
      end else begin
        m_out_flush = 1'b1;
      end
    end
    if (deliverable && !consumed) begin
      m_fifo_inst.push_back(r_inst);
      m_fifo_pc.push_back(r_addr);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int          t0;
    int          acc0;
    logic [31:0] last_pc;
    logic        prev_redir;
    logic        r_en, r_stall, r_redir, r_ready;
    logic [31:0] r_rpc;
    logic        ready_pat [4];

    @(negedge clk);
    do_reset(3);

    // Straight-line streaming, single-cycle memory.
    lat_min = 1;
    lat_max = 1;
    clear_log();
    t0 = cyc;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check("first_deliv_pc", deliv_pc[0], 32'h100);
    check("second_deliv_pc", deliv_pc[1], 32'h104);
    check("first_latency", 32'(deliv_cyc[0] - t0), BYP ? 32'd1 : 32'd2);
    check("stream_count", 32'(deliv_pc.size()), BYP ? 32'd11 : 32'd10);
    check_contig("stream_contig");

    // Stall while streaming: credit closes, outputs hold, no PC lost on release.
    last_pc = deliv_pc[deliv_pc.size()-1];
    clear_log();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("stall_req_low", 32'(imem_req), 32'd0);
    check("stall_no_deliv", 32'(deliv_pc.size()), 32'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check("stall_resume_pc", deliv_pc[0], last_pc + 32'd4);
    check_contig("stall_contig");

    // Redirect with three-cycle memory latency: stale responses dropped.
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h200, 1'b1);
    check("redir_flush", 32'(out_flush), 32'd1);
    clear_log();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check("redir_first_pc", deliv_pc[0], 32'h200);
    check_contig("redir_contig");

    // Redirect while stalled with a full FIFO.
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("model_fifo_full", 32'(m_fifo_pc.size()), 32'd4);
    step(1'b1, 1'b1, 1'b1, 32'h300, 1'b1);
    redirect = 1'b0;
    #1;
    check("stall_redir_flush", 32'(out_flush), 32'd1);
    check("stall_redir_req", 32'(imem_req), 32'd1);
    check("stall_redir_addr", imem_addr, 32'h300);
    clear_log();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check("stall_redir_first_pc", deliv_pc[0], 32'h300);
    check_contig("stall_redir_contig");

    // imem_ready pattern 1,0,0,1.
    ready_pat[0] = 1'b1;
    ready_pat[1] = 1'b0;
    ready_pat[2] = 1'b0;
    ready_pat[3] = 1'b1;
    clear_log();
    acc0 = acc_cnt;
    for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 1'b0, '0, ready_pat[i % 4]);
    check("toggle_accepts", 32'(acc_cnt - acc0), 32'd12);
    check_contig("toggle_contig");

    // Randomized traffic, with a reset part-way through.
    lat_min    = 1;
    lat_max    = 4;
    prev_redir = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2500) begin
        do_reset(2);
        prev_redir = 1'b0;
      end
      r_en    = ($urandom_range(9, 0) != 0);
      r_stall = ($urandom_range(3, 0) == 0);
      r_ready = ($urandom_range(9, 0) < 7);
      r_redir = !prev_redir && ($urandom_range(19, 0) == 0);
      r_rpc   = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      step(r_en, r_stall, r_redir, r_rpc, r_ready);
      prev_redir = r_redir;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
